gcm_aes: RTL and testbench

GCM_AES -- requirements
Module: gcm_aes

---
 rtl/gcm_aes.sv | 271 +++++++++++++++++++++++++++
 tb/tb_gcm_aes.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gcm_aes.sv
// AES-128-GCM engine (96-bit IV, optional single AAD block) on a fixed-latency schedule.
// Define GCM_AES_DECRYPT_EN to add i_decrypt: input blocks are ciphertext and GHASH runs over them.
package gcm_aes_pkg;
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // S-box from the field inverse (b^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf8_mul(sq, sq);
            inv = gf8_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]  a [16];
        logic [7:0]  b [16];
        logic [7:0]  b0, b1, b2, b3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) b[w+4*c] = a[w + 4*((c+w)%4)];
        for (int c = 0; c < 4; c++) begin
            b0 = b[4*c]; b1 = b[4*c+1]; b2 = b[4*c+2]; b3 = b[4*c+3];
            if (last) r[127-32*c -: 32] = {b0, b1, b2, b3};
            else      r[127-32*c -: 32] = {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
                                           b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
                                           b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
                                           xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
        end
        return r ^ rk;
    endfunction

    // GF(2^128) product in GCM's reflected bit order (bit 127 is the x^0 coefficient)
    function automatic logic [127:0] gf128_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction
endpackage

module key_expansion
    import gcm_aes_pkg::*;
(
    input  logic [127:0]       key,
    output logic [10:0][127:0] round_keys
);
    always_comb begin
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
endmodule

module aes_encrypt
    import gcm_aes_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [127:0] blk,
    output logic [127:0] ct
);
    logic [127:0]       key_r, blk_r, enc;
    logic [10:0][127:0] rk;
    logic [127:0]       pipe [LATENCY];

    key_expansion u_kexp (.key(key_r), .round_keys(rk));

    always_comb begin
        enc = blk_r ^ rk[0];
        for (int r = 1; r < 11; r++) enc = aes_round(enc, rk[r], r == 10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r <= '0;
            blk_r <= '0;
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            key_r   <= key;
            blk_r   <= blk;
            pipe[0] <= enc;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign ct = pipe[LATENCY-1];
endmodule

module gcm_aes
    import gcm_aes_pkg::*;
#(
    parameter int NUM_BLOCKS  = 4,
    parameter int AES_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_new_instance,
    input  logic [0:127] i_cipher_key,
    input  logic [0:95]  i_iv,
    input  logic         i_aad_en,
    input  logic [0:127] i_aad,
    input  logic [0:127] i_plain_text,
`ifdef GCM_AES_DECRYPT_EN
    input  logic         i_decrypt,
`endif
    output logic [0:127] o_cipher_text,
    output logic         o_ct_valid,
    output logic [0:127] o_tag,
    output logic         o_tag_ready
);
    localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    // Edge indices relative to the start edge (edge 0)
    localparam logic [7:0] LAST_PT  = 8'(NUM_BLOCKS - 1);
    localparam logic [7:0] NB8      = 8'(NUM_BLOCKS);
    localparam logic [7:0] CT_FIRST = 8'(AES_LATENCY + 1);
    localparam logic [7:0] CT_LAST  = 8'(NUM_BLOCKS + AES_LATENCY);
    localparam logic [7:0] H_CAP    = 8'(NUM_BLOCKS + AES_LATENCY + 1);
    localparam logic [7:0] GH_FIRST = 8'(NUM_BLOCKS + AES_LATENCY + 2);
    localparam logic [7:0] GH_LAST  = 8'(2*NUM_BLOCKS + AES_LATENCY + 3);
    localparam logic [7:0] TAG_EDGE = 8'(2*NUM_BLOCKS + AES_LATENCY + 4);

    typedef enum logic [1:0] {IDLE, ENC, HASH, DONE} state_t;
    state_t state, state_n;

    logic [7:0]   cnt, gh_idx;
    logic [127:0] key_r, aad_r, h_r, ej0_r, x_r;
    logic [95:0]  iv_r;
    logic         aad_en_r;
    logic [127:0] pt_buf [2**IW];
    logic [127:0] ct_buf [2**IW];
    logic [127:0] aes_key, aes_blk, aes_out, ct_blk, gh_blk;
    logic [IW-1:0] ct_idx;

`ifdef GCM_AES_DECRYPT_EN
    logic dec_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              dec_r <= 1'b0;
        else if (i_new_instance) dec_r <= i_decrypt;
    end
`else
    logic dec_r;
    assign dec_r = 1'b0;
`endif

    // The start edge issues straight from the ports; later issues use the captured copies
    always_comb begin
        aes_key = i_new_instance ? i_cipher_key : key_r;
        if (i_new_instance)     aes_blk = {i_iv, 32'd2};
        else if (cnt <= LAST_PT) aes_blk = {iv_r, 32'(cnt) + 32'd2};
        else if (cnt == NB8)    aes_blk = '0;
        else                    aes_blk = {iv_r, 32'd1};
    end

    aes_encrypt #(.LATENCY(AES_LATENCY)) u_aes (
        .clk(clk), .rst_n(rst_n), .key(aes_key), .blk(aes_blk), .ct(aes_out)
    );

    assign ct_idx = IW'(cnt - CT_FIRST);
    assign ct_blk = pt_buf[ct_idx] ^ aes_out;
    assign gh_idx = cnt - GH_FIRST;

    // Fixed GHASH slots: AAD (zero if absent), C1..CN, then the length block
    always_comb begin
        if (gh_idx == 8'd0)      gh_blk = aad_en_r ? aad_r : '0;
        else if (gh_idx <= NB8)  gh_blk = dec_r ? pt_buf[IW'(gh_idx - 8'd1)]
                                                : ct_buf[IW'(gh_idx - 8'd1)];
        else                     gh_blk = {56'd0, aad_en_r, 7'd0, 64'(128*NUM_BLOCKS)};
    end

    always_comb begin
        state_n = state;
        if (i_new_instance) state_n = ENC;
        else begin
            case (state)
                ENC:     if (cnt == H_CAP) state_n = HASH;
                HASH:    if (cnt == TAG_EDGE) state_n = DONE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            key_r         <= '0;
            iv_r          <= '0;
            aad_en_r      <= 1'b0;
            aad_r         <= '0;
            h_r           <= '0;
            ej0_r         <= '0;
            x_r           <= '0;
            o_cipher_text <= '0;
            o_ct_valid    <= 1'b0;
            o_tag         <= '0;
            o_tag_ready   <= 1'b0;
            for (int i = 0; i < 2**IW; i++) begin
                pt_buf[i] <= '0;
                ct_buf[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (i_new_instance) begin
                cnt         <= 8'd1;
                key_r       <= i_cipher_key;
                iv_r        <= i_iv;
                aad_en_r    <= i_aad_en;
                aad_r       <= i_aad;
                pt_buf[0]   <= i_plain_text;
                x_r         <= '0;
                o_ct_valid  <= 1'b0;
                o_tag       <= '0;
                o_tag_ready <= 1'b0;
            end else if (state == ENC || state == HASH) begin
                cnt        <= cnt + 8'd1;
                o_ct_valid <= 1'b0;
                if (cnt <= LAST_PT) pt_buf[IW'(cnt)] <= i_plain_text;
                if (cnt >= CT_FIRST && cnt <= CT_LAST) begin
                    o_cipher_text  <= ct_blk;
                    ct_buf[ct_idx] <= ct_blk;
                    o_ct_valid     <= 1'b1;
                end
                if (cnt == H_CAP)    h_r   <= aes_out;
                if (cnt == GH_FIRST) ej0_r <= aes_out;
                if (cnt >= GH_FIRST && cnt <= GH_LAST) x_r <= gf128_mul(x_r ^ gh_blk, h_r);
                if (cnt == TAG_EDGE) begin
                    o_tag       <= x_r ^ ej0_r;
                    o_tag_ready <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gcm_aes.sv
// Directed bench for gcm_aes: NIST GCM vectors on a 1-block and a 4-block instance.
module tb_gcm_aes;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         ni1, ni4, aad_en;
    logic [0:127] key, aad, pt;
    logic [0:95]  iv;
    logic [0:127] ct1, ct4, tag1, tag4;
    logic         ctv1, ctv4, tr1, tr4;
    logic         dec_v = 1'b0;
`ifdef GCM_AES_DECRYPT_EN
    logic         dec;
`endif
    int total = 0;
    int bad = 0;

    logic [127:0] in_v  [8];
    logic [127:0] exp_v [8];
    logic [127:0] aad_v = 128'hfeedfacedeadbeeffeedfacedeadbeef;

    localparam logic [127:0] TC3_KEY = 128'hfeffe9928665731c6d6a8f9467308308;
    localparam logic [95:0]  TC3_IV  = 96'hcafebabefacedbaddecaf888;
    localparam logic [127:0] TC3_H   = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] TC3_EJ0 = 128'h3247184b3c4f69a44dbcd22887bbb418;
    localparam logic [127:0] TC3_TAG = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
    localparam logic [127:0] TC2_CT  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TC2_TAG = 128'hab6e47d42cec13bdf53a67b21257bddf;
    logic [127:0] tc3_pt [4] = '{128'hd9313225f88406e5a55909c5aff5269a,
                                 128'h86a7a9531534f7da2e4c303d8a318a72,
                                 128'h1c3c0c95956809532fcf0e2449a6b525,
                                 128'hb16aedf5aa0de657ba637b391aafd255};
    logic [127:0] tc3_ct [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                                 128'he3aa212f2c02a4e035c17e2329aca12e,
                                 128'h21d514b25466931c7d8f6a5aac84aa05,
                                 128'h1ba30b396a0aac973d58e091473f5985};

    always #5 clk = ~clk;

    gcm_aes #(.NUM_BLOCKS(1), .AES_LATENCY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_new_instance(ni1), .i_cipher_key(key), .i_iv(iv),
        .i_aad_en(aad_en), .i_aad(aad), .i_plain_text(pt),
`ifdef GCM_AES_DECRYPT_EN
        .i_decrypt(dec),
`endif
        .o_cipher_text(ct1), .o_ct_valid(ctv1), .o_tag(tag1), .o_tag_ready(tr1)
    );

    gcm_aes #(.NUM_BLOCKS(4), .AES_LATENCY(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_new_instance(ni4), .i_cipher_key(key), .i_iv(iv),
        .i_aad_en(aad_en), .i_aad(aad), .i_plain_text(pt),
`ifdef GCM_AES_DECRYPT_EN
        .i_decrypt(dec),
`endif
        .o_cipher_text(ct4), .o_ct_valid(ctv4), .o_tag(tag4), .o_tag_ready(tr4)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Horner-form GF(2^128) multiply, reflected bit order
    function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] z;
        z = '0;
        for (int i = 127; i >= 0; i--) begin
            z = z[0] ? ((z >> 1) ^ {8'he1, 120'd0}) : (z >> 1);
            if (a[127-i]) z = z ^ b;
        end
        return z;
    endfunction

    function automatic logic [127:0] junk128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One instance: start at edge 0, inputs junk outside their edges, check outputs per edge
    task automatic run(input int sel, input int nb, input int lat, input logic [127:0] k,
                       input logic [95:0] v, input logic ae, input logic [127:0] exp_tag,
                       input string nm);
        int tag_e, nct, early;
        logic cv, tv;
        logic [127:0] cd, td;
        tag_e = 2*nb + lat + 4;
        nct = 0;
        early = 0;
        for (int e = 0; e <= tag_e + 2; e++) begin
            if (e == 0) begin
                if (sel == 1) ni1 = 1'b1; else ni4 = 1'b1;
                key = k; iv = v; aad_en = ae; aad = aad_v;
`ifdef GCM_AES_DECRYPT_EN
                dec = dec_v;
`endif
            end else begin
                ni1 = 1'b0; ni4 = 1'b0;
                key = junk128(); iv = {$urandom, $urandom, $urandom}; aad_en = ~ae; aad = junk128();
`ifdef GCM_AES_DECRYPT_EN
                dec = ~dec_v;
`endif
            end
            pt = (e < nb) ? in_v[e] : junk128();
            @(posedge clk);
            #1;
            cv = (sel == 1) ? ctv1 : ctv4;
            cd = (sel == 1) ? ct1 : ct4;
            tv = (sel == 1) ? tr1 : tr4;
            td = (sel == 1) ? tag1 : tag4;
            if (cv) begin
                if (nct < nb) begin
                    chk($sformatf("%s_ct%0d", nm, nct), cd, exp_v[nct]);
                    chk($sformatf("%s_ct%0d_edge", nm, nct), 128'(e), 128'(nct + lat + 1));
                end
                nct++;
            end
            if (e < tag_e && tv) early++;
            if (e >= tag_e) begin
                chk($sformatf("%s_tag_ready_e%0d", nm, e), {127'd0, tv}, 128'd1);
                chk($sformatf("%s_tag_e%0d", nm, e), td, exp_tag);
            end
        end
        chk($sformatf("%s_ct_count", nm), 128'(nct), 128'(nb));
        chk($sformatf("%s_early_tag", nm), 128'(early), 128'd0);
    endtask

    initial begin
        logic [127:0] x, tag_aad;
        rst_n = 1'b0; ni1 = 1'b0; ni4 = 1'b0; aad_en = 1'b0;
        key = '0; iv = '0; aad = '0; pt = '0;
`ifdef GCM_AES_DECRYPT_EN
        dec = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ct_valid", {127'd0, ctv4}, 128'd0);
        chk("rst_tag_ready", {127'd0, tr4}, 128'd0);
        chk("rst_tag", tag4, 128'd0);
        chk("rst_ct", ct1, 128'd0);
        rst_n = 1'b1;

        // Zero key/IV/plaintext, single block, first edge after reset release
        in_v[0] = '0; exp_v[0] = TC2_CT;
        run(1, 1, 2, '0, '0, 1'b0, TC2_TAG, "tc2");

        for (int i = 0; i < 4; i++) begin in_v[i] = tc3_pt[i]; exp_v[i] = tc3_ct[i]; end
        run(4, 4, 1, TC3_KEY, TC3_IV, 1'b0, TC3_TAG, "tc3");

        x = gmul(aad_v, TC3_H);
        for (int i = 0; i < 4; i++) x = gmul(x ^ tc3_ct[i], TC3_H);
        x = gmul(x ^ {64'd128, 64'd512}, TC3_H);
        tag_aad = x ^ TC3_EJ0;
        run(4, 4, 1, TC3_KEY, TC3_IV, 1'b1, tag_aad, "tc3aad");

        // Abort: a throwaway instance restarted at its edge 2
        ni4 = 1'b1; key = junk128(); iv = {$urandom, $urandom, $urandom}; aad_en = 1'b1;
        pt = junk128();
        @(posedge clk); #1;
        ni4 = 1'b0; pt = junk128();
        @(posedge clk); #1;
        run(4, 4, 1, TC3_KEY, TC3_IV, 1'b0, TC3_TAG, "abort");

        // Reset dropped while hashing (edges 7..13 of a 4-block instance)
        ni4 = 1'b1; key = TC3_KEY; iv = TC3_IV; aad_en = 1'b0; pt = tc3_pt[0];
        @(posedge clk); #1;
        ni4 = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            pt = (e < 4) ? tc3_pt[e] : junk128();
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ct", ct4, 128'd0);
        chk("midrst_ct_valid", {127'd0, ctv4}, 128'd0);
        chk("midrst_tag_ready", {127'd0, tr4}, 128'd0);
        chk("midrst_tag", tag4, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(4, 4, 1, TC3_KEY, TC3_IV, 1'b1, tag_aad, "postrst");

`ifdef GCM_AES_DECRYPT_EN
        dec_v = 1'b1;
        for (int i = 0; i < 4; i++) begin in_v[i] = tc3_ct[i]; exp_v[i] = tc3_pt[i]; end
        run(4, 4, 1, TC3_KEY, TC3_IV, 1'b0, TC3_TAG, "decrypt");
        dec_v = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
